// File: rtl/seq_shift_if.sv
// Operand/result bundle for seq_shift_unit. SEQ_SHIFT_ROTATE_EN adds the in_rot operand bit.
// Both sides are valid/ready: a transfer happens on the rising edge where valid and ready are both high.
// A source holds its payload steady from the time it raises valid until that edge.
interface seq_shift_if #(
   parameter int XLEN = 32,
   parameter int SHW  = 5
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_data;
   logic [SHW-1:0]  in_shamt;
   logic            in_l_or_r;
   logic            in_a_or_l;
`ifdef SEQ_SHIFT_ROTATE_EN
   logic            in_rot;
`endif
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_data;

   modport master (
`ifdef SEQ_SHIFT_ROTATE_EN
      output in_rot,
`endif
      output in_valid, in_data, in_shamt, in_l_or_r, in_a_or_l,
      input  in_ready,
      input  out_valid, out_data,
      output out_ready
   );

   modport slave (
`ifdef SEQ_SHIFT_ROTATE_EN
      input  in_rot,
`endif
      input  in_valid, in_data, in_shamt, in_l_or_r, in_a_or_l,
      output in_ready,
      output out_valid, out_data,
      input  out_ready
   );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRL/SRA engine shifting STEP bits per cycle behind valid/ready handshakes.
// Optional feature macro: SEQ_SHIFT_ROTATE_EN adds ROL/ROR selected by bus.in_rot.
module seq_shift_unit #(
   parameter int XLEN = 32,
   parameter int SHW  = 5,
   parameter int STEP = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   seq_shift_if.slave  bus,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);
   localparam logic [SHW:0] XLEN_W = (SHW+1)'(XLEN);

   state_t          state_q, state_d;
   logic [SHW-1:0]  rem_q, rem_d;
   logic [XLEN-1:0] work_q, work_d;
   logic            left_q, left_d;
   logic            arith_q, arith_d;
   logic            sign_q, sign_d;
`ifdef SEQ_SHIFT_ROTATE_EN
   logic            rot_q, rot_d;
`endif
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] out_data_q, out_data_d;

   logic [SHW:0]    rem_w;
   logic [SHW:0]    k_w;
   logic [XLEN-1:0] fill_mask;
   logic [XLEN-1:0] stepped;

   // Bits moved this cycle: a full STEP, or whatever is left on the final cycle.
   assign rem_w = {1'b0, rem_q};
   assign k_w   = (rem_w < STEP_W) ? rem_w : STEP_W;

   always_comb begin
      fill_mask = ~({XLEN{1'b1}} >> k_w);
      stepped   = left_q ? (work_q << k_w) : (work_q >> k_w);
      if (!left_q && arith_q && sign_q) begin
         stepped = stepped | fill_mask;
      end
`ifdef SEQ_SHIFT_ROTATE_EN
      // A shift by XLEN yields zero, so k = 0 leaves the rotate an identity.
      if (rot_q) begin
         stepped = left_q ? ((work_q << k_w) | (work_q >> (XLEN_W - k_w)))
                          : ((work_q >> k_w) | (work_q << (XLEN_W - k_w)));
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      work_d      = work_q;
      left_d      = left_q;
      arith_d     = arith_q;
      sign_d      = sign_q;
`ifdef SEQ_SHIFT_ROTATE_EN
      rot_d       = rot_q;
`endif
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (flush) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         rem_d       = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  work_d  = bus.in_data;
                  left_d  = bus.in_l_or_r;
                  sign_d  = bus.in_data[XLEN-1];
                  rem_d   = bus.in_shamt;
`ifdef SEQ_SHIFT_ROTATE_EN
                  rot_d   = bus.in_rot;
                  arith_d = bus.in_a_or_l & ~bus.in_l_or_r & ~bus.in_rot;
`else
                  arith_d = bus.in_a_or_l & ~bus.in_l_or_r;
`endif
                  if (bus.in_shamt != '0) begin
                     state_d = SHIFT;
                  end else begin
                     state_d     = DONE;
                     out_valid_d = 1'b1;
                     out_data_d  = bus.in_data;
                  end
               end
            end
            SHIFT: begin
               work_d = stepped;
               rem_d  = rem_q - k_w[SHW-1:0];
               if (rem_d == '0) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  out_data_d  = stepped;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b0;
               end
            end
            default: begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               rem_d       = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         work_q      <= '0;
         left_q      <= 1'b0;
         arith_q     <= 1'b0;
         sign_q      <= 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
         rot_q       <= 1'b0;
`endif
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         work_q      <= work_d;
         left_q      <= left_d;
         arith_q     <= arith_d;
         sign_q      <= sign_d;
`ifdef SEQ_SHIFT_ROTATE_EN
         rot_q       <= rot_d;
`endif
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign dbg_state     = state_q;

   // Invariants: a held result never changes, and an idle unit has nothing pending.
   a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid_q && !bus.out_ready && !flush) |=> $stable(out_data_q));
   a_idle_quiet : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == IDLE) |-> (!out_valid_q && rem_q == '0));

endmodule
